signal_period_meter: RTL

Receiving end of the square-wave output produced by the LED/clock counter block. It samples an asynchronous square wave, measures its period and high time in `in_clk` cycles, and flags when the waveform is stable or has stopped. Results drive the board LEDs, and other logic can read them. It lets the team confirm on hardware that the PLL-derived test output toggles at the expected rate.

---
 rtl/signal_period_meter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/signal_period_meter.sv
// Measures period and high time of an asynchronous square wave in in_clk cycles, with lock/loss flags.
// Optional 2-cycle glitch filter after the synchronizer: define SIGNAL_PERIOD_METER_GLITCH_FILTER_EN.
module signal_period_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 32'h0000_FFFF,
  parameter int unsigned MATCH_COUNT = 4
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             lost,
  output logic [5:0]       led
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = TIMEOUT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       MATCH_C   = MATCH_COUNT[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    LOST = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, s_d_q, s_s;
  logic             rise_s, fall_s, timeout_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_time_q, high_time_d;
  logic             valid_q, valid_d, locked_q, locked_d, lost_q, lost_d;
  logic [3:0]       match_q, match_d;
  logic [5:0]       led_q, led_d;

  // Two-flop synchronizer plus the delay flop used for edge detection
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_d_q   <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      s_d_q   <= s_s;
    end
  end

`ifdef SIGNAL_PERIOD_METER_GLITCH_FILTER_EN
  logic hold_q, filt_q;

  // Stability filter: follow the synchronized input only after two equal samples
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      hold_q <= sync2_q;
      if (sync2_q == hold_q) begin
        filt_q <= sync2_q;
      end
    end
  end

  assign s_s = filt_q;
`else
  assign s_s = sync2_q;
`endif

  assign rise_s    = s_s & ~s_d_q;
  assign fall_s    = ~s_s & s_d_q;
  assign timeout_s = (cnt_q == TIMEOUT_C);

  // Saturating cycle counter restarted by each rising edge; high time captured on falling edge
  always_comb begin
    cnt_d    = cnt_q;
    hi_cnt_d = hi_cnt_q;
    if (rise_s) begin
      cnt_d = CNT_ONE_C;
    end else if (!timeout_s) begin
      cnt_d = cnt_q + CNT_ONE_C;
    end else begin
      cnt_d = cnt_q;
    end
    if (fall_s) begin
      hi_cnt_d = cnt_q;
    end else begin
      hi_cnt_d = hi_cnt_q;
    end
  end

  // Measurement FSM, match counting and output next-state
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    lost_d      = 1'b0;
    match_d     = match_q;
    // lock follows the cycle after the match count completes
    locked_d    = locked_q | (match_q == MATCH_C);
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = HIGH;
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        if (fall_s) begin
          state_d = LOW;
        end else if (timeout_s) begin
          state_d  = LOST;
          lost_d   = 1'b1;
          locked_d = 1'b0;
          match_d  = 4'd0;
        end else begin
          state_d = HIGH;
        end
      end
      LOW: begin
        if (rise_s) begin
          state_d     = HIGH;
          period_d    = cnt_q;
          high_time_d = hi_cnt_q;
          valid_d     = 1'b1;
          if (cnt_q == period_q) begin
            if (match_q == MATCH_C) begin
              match_d = MATCH_C;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else begin
            match_d  = 4'd0;
            locked_d = 1'b0;
          end
        end else if (timeout_s) begin
          state_d  = LOST;
          lost_d   = 1'b1;
          locked_d = 1'b0;
          match_d  = 4'd0;
        end else begin
          state_d = LOW;
        end
      end
      LOST: begin
        state_d  = IDLE;
        locked_d = 1'b0;
        match_d  = 4'd0;
      end
      default: begin
        state_d  = IDLE;
        locked_d = 1'b0;
        match_d  = 4'd0;
      end
    endcase
    led_d = locked_d ? ~period_d[5:0] : 6'b111111;
  end

  // State and output registers
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      hi_cnt_q    <= {CNT_W{1'b0}};
      period_q    <= {CNT_W{1'b0}};
      high_time_q <= {CNT_W{1'b0}};
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
      match_q     <= 4'd0;
      led_q       <= 6'b111111;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      lost_q      <= lost_d;
      match_q     <= match_d;
      led_q       <= led_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign lost      = lost_q;
  assign led       = led_q;

endmodule
